// File: rtl/mem_pkg.sv
// Shared types and default widths for the fetch/load-store memory arbiter.
package mem_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   localparam int TMO_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the side that did not own the last transaction wins.
module rr_arb2
   import mem_pkg::*;
(
   input  logic       req_if,
   input  logic       req_ls,
   input  owner_e     last_owner,
   output logic [1:0] gnt          // [0] fetch, [1] load-store
);

   always_comb begin
      gnt = 2'b00;
      if (req_if && req_ls) begin
         gnt = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
      end else if (req_if) begin
         gnt = 2'b01;
      end else if (req_ls) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and load-store requests onto one memory port, one transaction at a time.
// Requesters hold req until a one-cycle gnt; rvalid is a one-cycle pulse with no back-pressure.
module mem_arb
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TMO_W  = TMO_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                err,
   output logic [1:0]          dbg_state
);

   localparam int MASK_W = DATA_W / 8;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                live_q, live_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                err_q, err_d;

   logic                arb_en;
   logic [1:0]          arb_gnt;
   logic                rsp_valid;
   logic [DATA_W-1:0]   rsp_data;

   // live_q keeps grants off for the first cycle after reset release
   assign live_d = 1'b1;
   assign arb_en = live_q && (state_q == ST_IDLE);

   rr_arb2 u_rr_arb2 (
      .req_if     (if_req && arb_en),
      .req_ls     (ls_req && arb_en),
      .last_owner (owner_q),
      .gnt        (arb_gnt)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_gnt[0]) begin
               owner_d = OWN_IF;
               addr_d  = if_addr;
               we_d    = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               tmo_d   = '0;
               state_d = ST_ISSUE;
            end else if (arb_gnt[1]) begin
               owner_d = OWN_LS;
               addr_d  = ls_addr;
               we_d    = ls_we;
               wdata_d = ls_wdata;
               wmask_d = ls_wmask;
               tmo_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            // A response accepted together with the grant finishes the transaction in ISSUE
            if ((state_q == ST_WAIT || mem_gnt) && mem_rvalid) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_rdata;
               state_d   = ST_IDLE;
            end else if (&tmo_q) begin
               rsp_valid = 1'b1;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (state_q == ST_ISSUE && mem_gnt) begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         live_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         live_q  <= live_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign if_gnt    = arb_gnt[0];
   assign ls_gnt    = arb_gnt[1];
   assign if_rvalid = rsp_valid && (owner_q == OWN_IF);
   assign ls_rvalid = rsp_valid && (owner_q == OWN_LS);
   assign if_rdata  = if_rvalid ? rsp_data : '0;
   assign ls_rdata  = ls_rvalid ? rsp_data : '0;

   assign mem_req   = (state_q == ST_ISSUE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized and directed bench for mem_arb against a memory responder and a transaction-level model.
module tb_mem_arb;

   logic        clk;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid;
   logic [63:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  ls_wmask;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        err;
   logic [1:0]  dbg_state;

   mem_arb #(.ADDR_W(64), .DATA_W(64), .TMO_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- bookkeeping ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- reference memory model ----------------
   logic [63:0] model_mem [logic [63:0]];
   logic [63:0] resp_mem  [logic [63:0]];
   logic [63:0] if_exp_q[$];
   logic [63:0] ls_exp_q[$];

   function automatic logic [63:0] mem_init(input logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] m);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] model_read(input logic [63:0] a);
      return model_mem.exists(a) ? model_mem[a] : mem_init(a);
   endfunction

   task automatic preload(input logic [63:0] a, input logic [63:0] d);
      model_mem[a] = d;
      resp_mem[a]  = d;
   endtask

   // Expected response for a load-store access; writes update the model in issue order.
   function automatic logic [63:0] ls_expect(input logic we, input logic [63:0] a,
                                             input logic [63:0] wd, input logic [7:0] m);
      logic [63:0] v;
      v = model_read(a);
      if (we) begin
         v = merge(v, wd, m);
         model_mem[a] = v;
      end
      return v;
   endfunction

   // ---------------- memory responder ----------------
   int rsp_mode  = 1;   // 0 never grants, 1 fixed delays, 2 random delays
   int fix_stall = 0;
   int fix_lat   = 1;

   initial begin : responder
      int stall_left;
      int pend_wait;
      int lat;
      bit pend;
      logic [63:0] pend_data;
      stall_left = -1;
      pend = 0;
      pend_wait = 0;
      pend_data = '0;
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = '0;
      forever begin
         step();
         mem_gnt = 0;
         mem_rvalid = 0;
         mem_rdata = '0;
         if (pend) begin
            if (pend_wait == 0) begin
               mem_rvalid = 1;
               mem_rdata = pend_data;
               pend = 0;
            end else pend_wait--;
         end else if (mem_req && rsp_mode != 0) begin
            if (stall_left < 0) stall_left = (rsp_mode == 1) ? fix_stall : $urandom_range(0, 3);
            if (stall_left == 0) begin
               mem_gnt = 1;
               stall_left = -1;
               pend_data = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : mem_init(mem_addr);
               if (mem_we) begin
                  pend_data = merge(pend_data, mem_wdata, mem_wmask);
                  resp_mem[mem_addr] = pend_data;
               end
               lat = (rsp_mode == 1) ? fix_lat : $urandom_range(0, 3);
               if (lat == 0) begin
                  mem_rvalid = 1;
                  mem_rdata = pend_data;
               end else begin
                  pend = 1;
                  pend_wait = lat - 1;
               end
            end else stall_left--;
         end else if (!mem_req) stall_left = -1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      bit busy;
      int last;
      int since;
      logic exp_i, exp_l;
      busy = 0;
      last = 0;
      since = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || since == 0) begin
            check("reset_outputs_quiet",
                  {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, err, dbg_state,
                   |if_rdata, |ls_rdata, |mem_addr, |mem_wdata, |mem_wmask}, 64'd0);
         end
         if (!rst_n) begin
            busy = 0;
            last = 0;
            since = 0;
            if_exp_q.delete();
            ls_exp_q.delete();
            continue;
         end
         exp_i = 0;
         exp_l = 0;
         if (!busy && since >= 1) begin
            if (if_req && ls_req) begin
               if (last == 0) exp_l = 1;
               else exp_i = 1;
            end else if (if_req) exp_i = 1;
            else if (ls_req) exp_l = 1;
         end
         check("arb_gnt", {if_gnt, ls_gnt}, {exp_i, exp_l});
         if (exp_i) begin busy = 1; last = 0; end
         if (exp_l) begin busy = 1; last = 1; end
         if (if_rvalid) begin
            if (if_exp_q.size() == 0) check("if_rsp_unexpected", if_rvalid, 0);
            else check("if_rdata", if_rdata, if_exp_q.pop_front());
            check("if_rsp_ls_quiet", {ls_rvalid, |ls_rdata}, 0);
            busy = 0;
         end
         if (ls_rvalid) begin
            if (ls_exp_q.size() == 0) check("ls_rsp_unexpected", ls_rvalid, 0);
            else check("ls_rdata", ls_rdata, ls_exp_q.pop_front());
            check("ls_rsp_if_quiet", {if_rvalid, |if_rdata}, 0);
            busy = 0;
         end
         since++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_gnt(input bit is_ls, output bit got);
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         got = is_ls ? ls_gnt : if_gnt;
      end
   endtask

   task automatic wait_drain(input string name);
      for (int c = 0; c < 200 && (if_exp_q.size() + ls_exp_q.size()) != 0; c++) step();
      check(name, 64'(if_exp_q.size() + ls_exp_q.size()), 0);
   endtask

   task automatic if_driver(input int n);
      logic [63:0] a;
      bit got;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) step();
         a = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 8;
         if_addr = a;
         if_req = 1;
         if_exp_q.push_back(model_read(a));
         wait_gnt(0, got);
         check("if_drv_gnt_seen", got, 1);
         step();
         if_req = 0;
         if_addr = {$urandom, $urandom};
      end
   endtask

   task automatic ls_driver(input int n);
      logic [63:0] a, wd;
      logic [7:0]  m;
      logic        we;
      bit got;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) step();
         a  = 64'h8000_1000 + 64'($urandom_range(0, 15)) * 8;
         wd = {$urandom, $urandom};
         m  = 8'($urandom_range(0, 255));
         we = 1'($urandom_range(0, 1));
         ls_addr = a;
         ls_wdata = wd;
         ls_wmask = m;
         ls_we = we;
         ls_req = 1;
         ls_exp_q.push_back(ls_expect(we, a, wd, m));
         wait_gnt(1, got);
         check("ls_drv_gnt_seen", got, 1);
         step();
         ls_req = 0;
         ls_wdata = {$urandom, $urandom};
      end
   endtask

   // ---------------- directed and random sequences ----------------
   initial begin : main
      bit got;
      int cnt, ni, nl, n;
      int order[4];
      int exp_order[4];
      logic seen;
      if_req = 0; if_addr = '0;
      ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
      rst_n = 0;
      preload(64'h8000_0000, 64'h0000_0000_0010_0073);
      preload(64'h8000_1040, 64'h1234_5678_8765_4321);
      repeat (3) step();
      rst_n = 1;
      step();

      // fetch: grant, issue, response on consecutive cycles
      fix_stall = 0; fix_lat = 1;
      if_addr = 64'h8000_0000; if_req = 1;
      if_exp_q.push_back(64'h0000_0000_0010_0073);
      @(negedge clk); check("t036_if_gnt_c0", if_gnt, 1);
      step(); if_req = 0; if_addr = '1;
      @(negedge clk);
      check("t036_mem_req_c1", mem_req, 1);
      check("t036_mem_addr", mem_addr, 64'h8000_0000);
      check("t036_fetch_we_mask", {mem_we, mem_wmask}, 0);
      step();
      @(negedge clk);
      check("t036_if_rvalid_c2", if_rvalid, 1);
      check("t036_if_rdata", if_rdata, 64'h0000_0000_0010_0073);
      check("t036_wait_no_req", mem_req, 0);
      step();

      // store with three stall cycles: fields held through ISSUE
      fix_stall = 3; fix_lat = 1;
      ls_req = 1; ls_we = 1; ls_addr = 64'h8000_1000;
      ls_wdata = 64'h8765_4321_1234_5678; ls_wmask = 8'hAA;
      ls_exp_q.push_back(ls_expect(1, 64'h8000_1000, 64'h8765_4321_1234_5678, 8'hAA));
      @(negedge clk); check("t038_ls_gnt", ls_gnt, 1);
      step(); ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '1; ls_wmask = 8'h55;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t038_issue_ctl", {mem_req, mem_we, mem_wmask}, {1'b1, 1'b1, 8'hAA});
         check("t038_issue_addr", mem_addr, 64'h8000_1000);
         check("t038_issue_wdata", mem_wdata, 64'h8765_4321_1234_5678);
         step();
      end
      @(negedge clk); check("t038_req_dropped", mem_req, 0);
      step();
      fix_stall = 0;
      ls_req = 1; ls_addr = 64'h8000_1000;
      ls_exp_q.push_back(ls_expect(0, 64'h8000_1000, '0, '0));
      wait_gnt(1, got); check("t038_readback_gnt", got, 1);
      step(); ls_req = 0;
      wait_drain("t038_drain");

      // tie from reset: ls, if, ls, if
      rsp_mode = 2;
      rst_n = 0;
      if_req = 1; if_addr = 64'h8000_0008;
      ls_req = 1; ls_we = 0; ls_addr = 64'h8000_1008;
      repeat (2) step();
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         if_exp_q.push_back(model_read(64'h8000_0008));
         ls_exp_q.push_back(model_read(64'h8000_1008));
      end
      step();
      n = 0; ni = 0; nl = 0;
      for (int i = 0; i < 4; i++) order[i] = 9;
      exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         @(negedge clk);
         if (if_gnt && n < 4) begin order[n] = 0; n++; ni++; end
         if (ls_gnt && n < 4) begin order[n] = 1; n++; nl++; end
         step();
         if (ni >= 2) if_req = 0;
         if (nl >= 2) ls_req = 0;
      end
      if_req = 0; ls_req = 0;
      for (int i = 0; i < 4; i++) check("t037_grant_order", 64'(order[i]), 64'(exp_order[i]));
      wait_drain("t037_drain");

      // timeout: memory never grants
      rsp_mode = 0;
      if_addr = 64'h8000_0010; if_req = 1;
      if_exp_q.push_back(64'd0);
      wait_gnt(0, got); check("t039_gnt", got, 1);
      step(); if_req = 0;
      cnt = 0; got = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (if_rvalid) begin got = 1; cnt = c; end
         else step();
      end
      check("t039_timeout_cycle", 64'(cnt), 16);
      step();
      rsp_mode = 1; fix_stall = 0; fix_lat = 1;
      ls_req = 1; ls_we = 0; ls_addr = 64'h8000_1018;
      ls_exp_q.push_back(ls_expect(0, 64'h8000_1018, '0, '0));
      @(negedge clk);
      check("t039_err_set", err, 1);
      check("t039_next_gnt", ls_gnt, 1);
      step(); ls_req = 0;
      wait_drain("t039_drain");
      check("t039_err_sticky", err, 1);

      // same-cycle grant and response, then a grant on the following cycle
      fix_stall = 0; fix_lat = 0;
      ls_req = 1; ls_we = 0; ls_addr = 64'h8000_1040;
      ls_exp_q.push_back(ls_expect(0, 64'h8000_1040, '0, '0));
      wait_gnt(1, got); check("t041_ls_gnt", got, 1);
      step(); ls_req = 0;
      if_req = 1; if_addr = 64'h8000_0020;
      if_exp_q.push_back(model_read(64'h8000_0020));
      @(negedge clk);
      check("t041_rvalid_in_issue", ls_rvalid, 1);
      check("t041_rdata", ls_rdata, 64'h1234_5678_8765_4321);
      check("t041_no_gnt_busy", if_gnt, 0);
      step();
      @(negedge clk); check("t041_gnt_next_cycle", if_gnt, 1);
      step(); if_req = 0;
      wait_drain("t041_drain");

      // reset during WAIT; the late response must be ignored
      fix_stall = 0; fix_lat = 6;
      rst_n = 0;
      repeat (2) step();
      rst_n = 1;
      step();
      if_req = 1; if_addr = 64'h8000_0028;
      if_exp_q.push_back(model_read(64'h8000_0028));
      wait_gnt(0, got); check("t040_gnt", got, 1);
      step(); if_req = 0;
      step();
      step(); rst_n = 0;
      step(); rst_n = 1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         seen = seen | if_rvalid | ls_rvalid;
         step();
      end
      check("t040_no_rvalid", seen, 0);
      check("t040_err_clear", err, 0);

      // random traffic from both requesters
      rsp_mode = 2;
      fork
         if_driver(40);
         ls_driver(40);
      join
      wait_drain("rand_drain");
      check("rand_err_clear", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 64, address width.
REQ-002 Parameter DATA_W, default 64, data width; wmask width is DATA_W/8.
REQ-003 Parameter TMO_W, default 8, response-timeout counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 if_req  in  1  fetch read request, held until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  one-cycle pulse, fetch request captured.
REQ-009 if_rvalid  out  1  one-cycle pulse, fetch response valid.
REQ-010 if_rdata  out  DATA_W  fetch read data, valid with if_rvalid.
REQ-011 ls_req, ls_we, ls_addr, ls_wdata, ls_wmask  in  1/1/ADDR_W/DATA_W/DATA_W/8  load-store request, held until ls_gnt.
REQ-012 ls_gnt, ls_rvalid  out  1 each; ls_rdata  out  DATA_W  load-store grant, response, data.
REQ-013 mem_req, mem_we  out  1 each; mem_addr, mem_wdata, mem_wmask  out  ADDR_W/DATA_W/DATA_W/8  shared memory port.
REQ-014 mem_gnt  in  1  memory accepted current mem_req.
REQ-015 mem_rvalid  in  1; mem_rdata  in  DATA_W  memory response, reads and writes alike.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 States IDLE, ISSUE, WAIT, one transaction outstanding.
REQ-018 IDLE: with any request, capture winner's fields into registers, pulse its gnt, record owner, go ISSUE next cycle.
REQ-019 Arbitration round-robin: both requesting -> grant requester that did not own last transaction; after reset ls wins first tie.
REQ-020 Single requester is granted in the IDLE cycle it asserts req; no idle bubble.
REQ-021 Fetch transactions force mem_we=0 and mem_wmask=0.
REQ-022 ISSUE: mem_req=1 with captured fields held stable; on mem_gnt go WAIT.
REQ-023 WAIT: mem_req=0; on mem_rvalid pulse owner rvalid, drive owner rdata = mem_rdata same cycle, go IDLE.
REQ-024 mem_gnt and mem_rvalid in same ISSUE cycle: response completes then, return to IDLE, skip WAIT.
REQ-025 Non-owner rvalid stays 0; non-owner rdata is 0.
REQ-026 Minimum transaction 3 cycles (grant, issue, response); next grant possible the cycle after response.
REQ-027 Timeout counter clears on grant, increments each ISSUE/WAIT cycle, saturates; at all-ones: set err, pulse owner rvalid with rdata 0, return to IDLE.
REQ-028 mem_rvalid in IDLE ignored (stray response), no output change.
REQ-029 Requests arriving during ISSUE/WAIT wait; gnt never pulses outside IDLE.

Reset
REQ-030 rst_n low: state IDLE, owner = fetch (so ls wins first tie), captured fields 0, counter 0, err 0.
REQ-031 All outputs 0 during reset and first cycle after release.
REQ-032 Reset mid-transaction abandons it; no rvalid issued for it; later mem_rvalid handled per REQ-028.
REQ-033 err clears only on reset.

Structure
REQ-034 State encoding and owner enum (OWN_IF, OWN_LS) in shared package mem_pkg; ADDR_W/DATA_W defaults there.
REQ-035 Arbitration in sub-module rr_arb2 (two req, last-owner in, one-hot grant out); rest flat.

Verification
REQ-036 Fetch only, addr 0x80000000, mem_gnt immediate, mem_rvalid next cycle rdata 0x00100073 -> if_gnt cycle 0, mem_req cycle 1, if_rvalid+rdata cycle 2.
REQ-037 if_req and ls_req both asserted from reset, 4 back-to-back -> grant order ls, if, ls, if.
REQ-038 ls store addr 0x80001000, wdata 0x8765432112345678, wmask 0xAA, mem_gnt after 3 stall cycles -> mem fields stable and mem_req high for all 4 ISSUE cycles.
REQ-039 mem_gnt never, TMO_W=4 -> after 15 cycles owner rvalid with rdata 0, err=1, next request serviced.
REQ-040 rst_n low during WAIT, then mem_rvalid after release -> no rvalid on either side, err 0.
REQ-041 mem_gnt and mem_rvalid same cycle, rdata 0x1234567887654321 -> rvalid that cycle, new grant following cycle.
